// File: rtl/nmr_voter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nmr_voter_ctrl
// Purpose  : N-modular redundancy voter with per-channel fault masking,
//            resynchronisation hold window and halt on loss of majority.
// Revision : 1.0 - initial release
// ============================================================================
module nmr_voter_ctrl #(
    parameter int N_CH       = 3,
    parameter int DATA_W     = 32,
    parameter int ERR_THRESH = 4,
    parameter int RESYNC_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [DATA_W-1:0]        voted_data,
    output logic                     voted_valid,
    output logic [N_CH-1:0]          mismatch,
    output logic [N_CH-1:0]          fault_ch,
    output logic                     core_hold,
    output logic [1:0]               state
);

    localparam int c_M = N_CH / 2 + 1;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_RESYNC   = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_err_cnt [N_CH];
    logic [7:0]          r_resync_cnt;

    logic [N_CH-1:0]     w_part;
    logic                w_has_maj;
    logic [DATA_W-1:0]   w_maj;
    logic [N_CH-1:0]     w_mis;
    logic [N_CH-1:0]     w_new_fault;
    logic [7:0]          w_cnt_nxt [N_CH];
    logic                w_vote;
    int                  w_n;
    int                  w_active_after;

    assign state = r_state;

    always_comb begin
        w_part      = ch_valid & ~fault_ch;
        w_has_maj   = 1'b0;
        w_maj       = '0;
        w_n         = 0;
        w_mis       = '0;
        w_new_fault = '0;
        w_active_after = 0;
        // First participating channel backed by M equal words is the majority
        for (int i = 0; i < N_CH; i++) begin
            w_n = 0;
            for (int j = 0; j < N_CH; j++) begin
                if (w_part[i] && w_part[j] &&
                    ch_data[i*DATA_W +: DATA_W] == ch_data[j*DATA_W +: DATA_W])
                    w_n++;
            end
            if (!w_has_maj && w_n >= c_M) begin
                w_has_maj = 1'b1;
                w_maj     = ch_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (w_has_maj)
                w_mis[i] = ~fault_ch[i] &
                           (~ch_valid[i] | (ch_data[i*DATA_W +: DATA_W] != w_maj));
            else
                w_mis[i] = ~fault_ch[i];
            w_cnt_nxt[i] = 8'd0;
            if (w_mis[i]) begin
                if (r_err_cnt[i] == 8'(ERR_THRESH - 1))
                    w_new_fault[i] = 1'b1;
                else
                    w_cnt_nxt[i] = r_err_cnt[i] + 8'd1;
            end
            if (!(fault_ch[i] || w_new_fault[i]))
                w_active_after++;
        end
        w_vote = ((r_state == ST_NORMAL) || (r_state == ST_DEGRADED)) && (|w_part);
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state      <= ST_NORMAL;
            voted_data   <= '0;
            voted_valid  <= 1'b0;
            mismatch     <= '0;
            fault_ch     <= '0;
            core_hold    <= 1'b0;
            r_resync_cnt <= 8'd0;
            for (int i = 0; i < N_CH; i++)
                r_err_cnt[i] <= 8'd0;
        end else begin
            voted_valid <= 1'b0;
            case (r_state)
                ST_NORMAL, ST_DEGRADED: begin
                    if (w_vote) begin
                        mismatch <= w_mis;
                        fault_ch <= fault_ch | w_new_fault;
                        for (int i = 0; i < N_CH; i++)
                            r_err_cnt[i] <= w_cnt_nxt[i];
                        if (!w_has_maj) begin
                            r_state   <= ST_HALT;
                            core_hold <= 1'b1;
                        end else if (|w_new_fault) begin
                            core_hold <= 1'b1;
                            if (w_active_after >= c_M) begin
                                r_state      <= ST_RESYNC;
                                r_resync_cnt <= 8'(RESYNC_CYC - 1);
                                mismatch     <= '0;
                            end else begin
                                r_state <= ST_HALT;
                            end
                        end else begin
                            voted_data  <= w_maj;
                            voted_valid <= 1'b1;
                        end
                    end
                end
                ST_RESYNC: begin
                    mismatch <= '0;
                    if (r_resync_cnt == 8'd0) begin
                        r_state   <= ST_DEGRADED;
                        core_hold <= 1'b0;
                    end else begin
                        r_resync_cnt <= r_resync_cnt - 8'd1;
                    end
                end
                default: begin
                    core_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/nmr_voter_ctrl.md
NMR_VOTER_CTRL -- requirements
Module: nmr_voter_ctrl

Interface
REQ-001 Parameter N_CH, default 3: number of redundant core channels; legal values 3 and 5.
REQ-002 Parameter DATA_W, default 32: width of one channel's voted payload in bits.
REQ-003 Parameter ERR_THRESH, default 4: number of consecutive mismatching cycles after which a channel is masked; legal range 1..255.
REQ-004 Parameter RESYNC_CYC, default 8: length of the core_hold window after a new fault, in cycles; legal range 1..255.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-007 Port ch_valid, input, N_CH bits: per-channel output-valid flag.
REQ-008 Port ch_data, input, N_CH*DATA_W bits: packed payloads; channel i occupies [i*DATA_W +: DATA_W].
REQ-009 Port voted_data, output, DATA_W bits: registered majority word.
REQ-010 Port voted_valid, output, 1 bit: registered; voted_data holds a new majority word this cycle.
REQ-011 Port mismatch, output, N_CH bits: registered; channel disagreed with the majority on the last vote.
REQ-012 Port fault_ch, output, N_CH bits: sticky mask of channels declared persistently faulty.
REQ-013 Port core_hold, output, 1 bit: stall request to the cores; high in RESYNC and HALT.
REQ-014 Port state, output, 2 bits: encoding NORMAL=0, DEGRADED=1, RESYNC=2, HALT=3.

Function
REQ-015 Active channel = fault_ch bit clear; participating channel = active and ch_valid set.
REQ-016 Majority threshold M = N_CH/2+1 (integer division), fixed by N_CH, not reduced by masking.
REQ-017 Majority exists when some participating channel's word equals the ch_data of at least M participating channels, itself included; the comparison is full-word equality. The majority word is that common value.
REQ-018 Vote cycle = state in {NORMAL, DEGRADED} and at least one participating channel. If no channel participates, the cycle is idle: voted_valid=0 and counters and mismatch are unchanged.
REQ-019 Vote cycle with a majority:
  - voted_data = majority word, voted_valid=1, with 1-cycle latency (inputs sampled at edge k appear after edge k).
  - mismatch[i] = active and (not valid or data differs).
  - mismatch is 0 for masked channels.
REQ-020 voted_data holds its previous value whenever voted_valid=0.
REQ-021 Per-channel error counter, 8 bits:
  - Increments on a vote cycle with mismatch[i]=1.
  - Clears to 0 on a vote cycle where channel i agrees.
  - Holds in RESYNC, HALT and idle cycles.
REQ-022 When an error counter reaches ERR_THRESH, fault_ch[i] sets on that same edge and the counter clears.
REQ-023 Vote cycle without a majority:
  - Go to HALT.
  - voted_valid=0.
  - mismatch set to all active channels.
REQ-024 State NORMAL: fault_ch all zero.
  - New fault with active count >= M: go to RESYNC.
  - New fault with active count < M: go to HALT.
REQ-025 State DEGRADED: at least one fault_ch bit set. Transitions are identical to NORMAL.
REQ-026 State RESYNC:
  - core_hold=1, voted_valid=0, mismatch=0.
  - A down-counter is loaded with RESYNC_CYC-1 on entry.
  - On expiry, go to DEGRADED; NORMAL is never re-entered without reset.
REQ-027 State HALT: core_hold=1, voted_valid=0, terminal until rst_in.
REQ-028 Several counters reaching ERR_THRESH on the same edge: all bits set together, and REQ-024 is evaluated on the resulting active count.
REQ-029 No-majority and a new fault on the same vote cycle: HALT takes priority.
REQ-030 Inputs are ignored in RESYNC and HALT.

Reset
REQ-031 rst_in high at a clock edge:
  - state=NORMAL.
  - voted_data=0, voted_valid=0, mismatch=0, fault_ch=0, core_hold=0.
  - All error and resync counters=0.
REQ-032 Reset overrides every state, including mid-RESYNC and HALT.
REQ-033 Outputs take reset values on the first edge with rst_in=1, and the first vote is accepted on the edge after rst_in falls.

Verification (N_CH=3, DATA_W=32, ERR_THRESH=4, RESYNC_CYC=8)
REQ-034 All channels valid with data 0x00000013 -> next cycle voted_data=0x00000013, voted_valid=1, mismatch=000, state=0.
REQ-035 ch2 data 0xDEADBEEF for 3 cycles, then agrees -> mismatch=100 for 3 cycles, counter returns to 0, fault_ch=000.
REQ-036 ch1 mismatches 4 consecutive cycles:
  - fault_ch=010, state=2, core_hold=1 for exactly 8 cycles.
  - Then state=1, and voting continues on ch0 and ch2.
REQ-037 In DEGRADED, ch0=0x1 and ch2=0x2 -> state=3, core_hold=1, voted_valid=0, and the block stays there until rst_in.
REQ-038 rst_in asserted during the 3rd RESYNC cycle -> next edge state=0, fault_ch=000, core_hold=0.
REQ-039 N_CH=5 with ch1 and ch3 both reaching ERR_THRESH on the same edge -> fault_ch=01010, state=2.
